pll_reset_seq: RTL and testbench

Sequences the board PLL (rPLL wrapper driven by the 27 MHz input) from power-up to a clean, lock-qualified system reset release. It runs on the 27 MHz reference clock, because the PLL output is not trustworthy before lock. It drives the PLL RESET pin, qualifies LOCK, retries on lock timeout and re-sequences on lock loss. Its sys_reset_n output feeds the top-level reset synchronizer of the game core.

---
 rtl/pll_reset_seq.sv | 170 +++++++++++++++++
 tb/tb_pll_reset_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// Purpose: sequences PLL reset, qualifies lock, and releases the lock-qualified active-low system reset.
// Latency: lock decisions lag pll_lock by 2 cycles (synchronizer); all outputs are registered with the state.
// Backpressure: none; relock_req forces a full re-sequence. Optional macro PLL_RESET_SEQ_LOSS_CNT_EN enables loss_cnt.
module pll_reset_seq #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 27000,
    parameter int SYS_RST_DELAY       = 256,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    // Shared down-counter is sized for the longest timed state.
    localparam int MAX_A = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_B = (LOCK_TIMEOUT_CYCLES > SYS_RST_DELAY) ? LOCK_TIMEOUT_CYCLES : SYS_RST_DELAY;
    localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          cnt_zero;
    logic          sync1;
    logic          lock_s;
    logic [3:0]    retry_d;
    logic [3:0]    retry_inc;
    logic          entry;
    logic          pll_reset_d;
    logic          sys_reset_n_d;
    logic          ready_d;
    logic          fault_d;

    // Counter value loaded on entry; the state then lasts (value + 1) cycles.
    function automatic logic [CW-1:0] load_val(input state_t s);
        case (s)
            S_HOLD:      load_val = CW'(RST_HOLD_CYCLES - 1);
            S_WAIT_LOCK: load_val = CW'(LOCK_TIMEOUT_CYCLES - 1);
            S_STABLE:    load_val = CW'(LOCK_STABLE_CYCLES - 1);
            S_RELEASE:   load_val = CW'(SYS_RST_DELAY - 1);
            default:     load_val = '0;
        endcase
    endfunction

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= pll_lock;
            lock_s <= sync1;
        end
    end

    assign cnt_zero  = (cnt == '0);
    assign retry_inc = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;

    // Next-state logic: relock_req first, then lock drop, then counter expiry.
    always_comb begin
        next_state = state;
        retry_d    = retry_cnt;
        if (relock_req) begin
            next_state = S_HOLD;
            retry_d    = 4'd0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt_zero) next_state = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        next_state = S_STABLE;
                    end else if (cnt_zero) begin
                        retry_d    = retry_inc;
                        next_state = (retry_inc == 4'(MAX_RETRIES)) ? S_FAULT : S_HOLD;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        next_state = S_WAIT_LOCK;
                    end else if (cnt_zero) begin
                        next_state = S_RELEASE;
                        retry_d    = 4'd0;
                    end
                end
                S_RELEASE: begin
                    if (!lock_s) next_state = S_HOLD;
                    else if (cnt_zero) next_state = S_RUN;
                end
                S_RUN: begin
                    if (!lock_s) next_state = S_HOLD;
                end
                S_FAULT: begin
                    next_state = S_FAULT;
                end
                default: begin
                    next_state = S_HOLD;
                end
            endcase
        end
        entry = relock_req || (next_state != state);
        cnt_d = entry ? load_val(next_state) : (cnt_zero ? cnt : cnt - CW'(1));
    end

    // Output decode from the next state so outputs register alongside the state.
    always_comb begin
        pll_reset_d   = (next_state == S_HOLD) || (next_state == S_FAULT);
        sys_reset_n_d = (next_state == S_RUN);
        ready_d       = (next_state == S_RUN);
        fault_d       = (next_state == S_FAULT);
    end

    // State, counter and output registers; reset counts as entering HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_HOLD;
            cnt         <= CW'(RST_HOLD_CYCLES - 1);
            retry_cnt   <= 4'd0;
            pll_reset   <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_d;
            retry_cnt   <= retry_d;
            pll_reset   <= pll_reset_d;
            sys_reset_n <= sys_reset_n_d;
            ready       <= ready_d;
            fault       <= fault_d;
        end
    end

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic loss_evt;
    assign loss_evt = !relock_req && !lock_s && ((state == S_RELEASE) || (state == S_RUN));

    // Saturating count of lock losses after qualification; cleared only by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loss_cnt <= 8'h00;
        end else if (loss_evt && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end
`else
    assign loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: phase/elapsed-time reference model with per-cycle compare,
// directed scenarios with literal timing expectations, then randomized lock/relock stimulus.
module tb_pll_reset_seq;

    localparam int P_RST  = 4;
    localparam int P_STB  = 8;
    localparam int P_TO   = 32;
    localparam int P_DLY  = 4;
    localparam int P_MAXR = 3;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    localparam int LOSS_ON = 1;
`else
    localparam int LOSS_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_reset;
    logic       sys_reset_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .RST_HOLD_CYCLES    (P_RST),
        .LOCK_STABLE_CYCLES (P_STB),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .SYS_RST_DELAY      (P_DLY),
        .MAX_RETRIES        (P_MAXR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_lock   (pll_lock),
        .relock_req (relock_req),
        .pll_reset  (pll_reset),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: named phase plus cycles elapsed in it, lock seen two samples late.
    localparam int M_HOLD  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_STAB  = 2;
    localparam int M_REL   = 3;
    localparam int M_RUN   = 4;
    localparam int M_FAULT = 5;

    int m_phase;
    int m_t;
    int m_retry;
    int m_loss;
    int m_nxt;
    bit m_ls;
    bit m_q[$];

    always begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_phase = M_HOLD;
            m_t     = 0;
            m_retry = 0;
            m_loss  = 0;
            m_q.delete();
            m_q.push_back(1'b0);
            m_q.push_back(1'b0);
        end else begin
            m_ls = m_q.pop_front();
            m_q.push_back(pll_lock === 1'b1);
            m_t++;
            m_nxt = m_phase;
            if (relock_req === 1'b1) begin
                m_nxt   = M_HOLD;
                m_retry = 0;
            end else begin
                case (m_phase)
                    M_HOLD: if (m_t == P_RST) m_nxt = M_WAIT;
                    M_WAIT: begin
                        if (m_ls) m_nxt = M_STAB;
                        else if (m_t == P_TO) begin
                            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                            m_nxt   = (m_retry == P_MAXR) ? M_FAULT : M_HOLD;
                        end
                    end
                    M_STAB: begin
                        if (!m_ls) m_nxt = M_WAIT;
                        else if (m_t == P_STB) begin
                            m_nxt   = M_REL;
                            m_retry = 0;
                        end
                    end
                    M_REL: begin
                        if (!m_ls) begin
                            m_nxt = M_HOLD;
                            if (m_loss < 255) m_loss++;
                        end else if (m_t == P_DLY) m_nxt = M_RUN;
                    end
                    M_RUN: begin
                        if (!m_ls) begin
                            m_nxt = M_HOLD;
                            if (m_loss < 255) m_loss++;
                        end
                    end
                    default: m_nxt = m_phase;
                endcase
            end
            if ((relock_req === 1'b1) || (m_nxt != m_phase)) m_t = 0;
            m_phase = m_nxt;
        end
    end

    // Compare every output against the model once per cycle, away from the active edge.
    always begin
        @(negedge clk);
        if (chk_en) begin
            chk("m_pll_reset", pll_reset, (m_phase == M_HOLD || m_phase == M_FAULT) ? 1 : 0);
            chk("m_sys_reset_n", sys_reset_n, (m_phase == M_RUN) ? 1 : 0);
            chk("m_ready", ready, (m_phase == M_RUN) ? 1 : 0);
            chk("m_fault", fault, (m_phase == M_FAULT) ? 1 : 0);
            chk("m_retry_cnt", retry_cnt, m_retry);
            chk("m_loss_cnt", loss_cnt, (LOSS_ON != 0) ? m_loss : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_relock(input logic lock_val);
        relock_req = 1'b1;
        pll_lock   = lock_val;
        tick();
        relock_req = 1'b0;
    endtask

    int n;
    int len;
    int cyc;

    initial begin
        reset_n    = 1'b0;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_pll_reset", pll_reset, 1);
        chk("rst_sys_reset_n", sys_reset_n, 0);
        chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0);
        chk("rst_retry_cnt", retry_cnt, 0);
        chk("rst_loss_cnt", loss_cnt, 0);
        chk_en  = 1'b1;
        reset_n = 1'b1;

        // Power-up: HOLD length, then lock 10 cycles after release.
        n = 0;
        do begin
            tick();
            n++;
        end while (pll_reset === 1'b1 && n < 50);
        chk("hold_len", n, P_RST);
        repeat (10 - P_RST) tick();
        pll_lock = 1'b1;
        tick();
        n = 0;
        while (sys_reset_n !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("lock_to_release", n, 2 + P_STB + P_DLY);
        chk("pwrup_ready", ready, 1);
        chk("pwrup_retry", retry_cnt, 0);

        // Lock never arrives: three timed-out attempts, then FAULT.
        pulse_relock(1'b0);
        n = 0;
        while (fault !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("fault_time", n, P_MAXR * (P_RST + P_TO));
        chk("fault_retry", retry_cnt, P_MAXR);
        chk("fault_pll_reset", pll_reset, 1);
        repeat (20) tick();
        chk("fault_sticky", fault, 1);

        // relock_req leaves FAULT; lock dropout mid-STABLE restarts qualification.
        pulse_relock(1'b1);
        chk("relock_fault_clr", fault, 0);
        chk("relock_retry_clr", retry_cnt, 0);
        chk("relock_hold", pll_reset, 1);
        repeat (8) tick();
        pll_lock = 1'b0;
        repeat (3) tick();
        chk("stable_drop_sysrst", sys_reset_n, 0);
        pll_lock = 1'b1;
        tick();
        n = 0;
        while (sys_reset_n !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("stable_restart", n, 2 + P_STB + P_DLY);
        chk("stable_no_retry", retry_cnt, 0);

        // Lock loss in RUN.
        pll_lock = 1'b0;
        tick();
        n = 0;
        while (pll_reset !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("loss_latency", n, 2);
        chk("loss_ready", ready, 0);
        chk("loss_sysrst", sys_reset_n, 0);
        chk("loss_cnt_1", loss_cnt, LOSS_ON);
        pll_lock = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("loss_recover", ready, 1);

        // relock_req in RUN: full sequence, no loss recorded.
        pulse_relock(1'b1);
        chk("relock_run_ready", ready, 0);
        chk("relock_run_hold", pll_reset, 1);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("relock_seq_len", n, P_RST + 1 + P_STB + P_DLY);
        chk("relock_loss_same", loss_cnt, LOSS_ON);

        // Asynchronous reset in the middle of RELEASE.
        pulse_relock(1'b1);
        repeat (P_RST + 1 + P_STB + 1) tick();
        #1 reset_n = 1'b0;
        #1;
        chk("arst_pll_reset", pll_reset, 1);
        chk("arst_sys_reset_n", sys_reset_n, 0);
        chk("arst_ready", ready, 0);
        chk("arst_fault", fault, 0);
        chk("arst_retry", retry_cnt, 0);
        chk("arst_loss", loss_cnt, 0);
        tick();
        reset_n = 1'b1;

        // Randomized lock segments with occasional relock pulses.
        cyc = 0;
        while (cyc < 3000) begin
            pll_lock = ($urandom_range(0, 2) != 0);
            len = pll_lock ? $urandom_range(1, 60) : $urandom_range(1, 150);
            for (int i = 0; i < len; i++) begin
                relock_req = ($urandom_range(0, 99) == 0);
                tick();
                relock_req = 1'b0;
                cyc++;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
